// File: rtl/grf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wport_arbiter
//
// Owns the single GRF write port of the P8 pipeline. The W-stage writeback
// (primary) always wins the port with zero latency. Writebacks from
// long-latency units (secondary: MDU, bus loads) are queued in a small FIFO
// and drained into cycles where the primary is idle. The block also reports
// pending-write hazards to decode and raises a registered stall request when
// the queue head has been denied the port for too long.
//
// Ports:
//   clk                      single clock, all state changes on rising edge
//   reset                    synchronous, active-low
//   p_we/p_a3/p_wd/p_pc      primary writeback request
//   s_valid/s_ready          secondary handshake (s_ready = !full)
//   s_a3/s_wd/s_pc           secondary writeback payload
//   grf_we/a3/wd/pc          write port towards the GRF (combinational)
//   q_rs/q_rt                decode register lookups
//   q_rs_busy/q_rt_busy      a queued valid entry targets that register
//   stall_req                registered request for a primary bubble
// -----------------------------------------------------------------------------
module grf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    input  logic [4:0]  q_rs,
    input  logic [4:0]  q_rt,
    output logic        q_rs_busy,
    output logic        q_rt_busy,
    output logic        stall_req
);

    localparam int             AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [3:0]     LIMIT      = 4'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] ent_v_q, ent_v_d;
    logic [4:0]       ent_a3_q [DEPTH];
    logic [4:0]       ent_a3_d [DEPTH];
    logic [31:0]      ent_wd_q [DEPTH];
    logic [31:0]      ent_wd_d [DEPTH];
    logic [31:0]      ent_pc_q [DEPTH];
    logic [31:0]      ent_pc_d [DEPTH];
    logic [3:0]       starve_q, starve_d;
    logic             stall_q, stall_d;

    // ------------------------------------------------------------------
    // Decode of current-cycle requests
    // ------------------------------------------------------------------
    logic        p_eff;
    logic        full;
    logic        non_empty;
    logic        head_v;
    logic [4:0]  head_a3;
    logic [31:0] head_wd;
    logic [31:0] head_pc;
    logic        push;
    logic        pop;
    logic        pop_valid;
    logic        starve_inc;

    logic [DEPTH-1:0] cancel_hit;
    logic [DEPTH-1:0] rs_hit;
    logic [DEPTH-1:0] rt_hit;

    assign p_eff     = p_we && (p_a3 != 5'd0);
    assign full      = (count_q == COUNT_FULL);
    assign non_empty = (count_q != '0);

    assign head_v  = ent_v_q[rd_ptr_q];
    assign head_a3 = ent_a3_q[rd_ptr_q];
    assign head_wd = ent_wd_q[rd_ptr_q];
    assign head_pc = ent_pc_q[rd_ptr_q];

    // No pass-through: a full queue refuses even when it pops this cycle.
    assign s_ready = reset && !full;

    // $0 requests complete the handshake but never occupy a slot.
    assign push = s_valid && s_ready && (s_a3 != 5'd0);

    // A cancelled head needs no port, so it leaves even under a primary write.
    assign pop        = reset && non_empty && (!p_eff || !head_v);
    assign pop_valid  = pop && head_v;
    assign starve_inc = reset && non_empty && head_v && p_eff;

    // Per-entry address comparators for cancellation and decode hazards.
    // Valid bits are cleared on pop, so a set bit always means "queued".
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry_cmp
            assign cancel_hit[gi] = p_eff && ent_v_q[gi] && (ent_a3_q[gi] == p_a3);
            assign rs_hit[gi]     = ent_v_q[gi] && (ent_a3_q[gi] == q_rs);
            assign rt_hit[gi]     = ent_v_q[gi] && (ent_a3_q[gi] == q_rt);
        end
    endgenerate

    assign q_rs_busy = (q_rs != 5'd0) && (|rs_hit);
    assign q_rt_busy = (q_rt != 5'd0) && (|rt_hit);
    assign stall_req = stall_q;

    // ------------------------------------------------------------------
    // Write port select: primary first, then a valid FIFO head
    // ------------------------------------------------------------------
    logic sel_we;

    always_comb begin
        sel_we = p_eff;
        grf_a3 = p_a3;
        grf_wd = p_wd;
        grf_pc = p_pc;
        if (!p_eff && pop_valid) begin
            sel_we = 1'b1;
            grf_a3 = head_a3;
            grf_wd = head_wd;
            grf_pc = head_pc;
        end
    end

    // The $0 guard is redundant with the request filters but keeps the
    // port safe regardless of how the select above evolves.
    assign grf_we = reset && sel_we && (grf_a3 != 5'd0);

    // ------------------------------------------------------------------
    // Next-state: pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: entries. Order matters: pop and cancel clear first,
    // then a same-edge push sets valid, so a new arrival survives a
    // primary write to the same register.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_v_d[i]  = ent_v_q[i];
            ent_a3_d[i] = ent_a3_q[i];
            ent_wd_d[i] = ent_wd_q[i];
            ent_pc_d[i] = ent_pc_q[i];
            if (pop && (rd_ptr_q == AW'(i))) begin
                ent_v_d[i] = 1'b0;
            end
            if (cancel_hit[i]) begin
                ent_v_d[i] = 1'b0;
            end
            if (push && (wr_ptr_q == AW'(i))) begin
                ent_v_d[i]  = 1'b1;
                ent_a3_d[i] = s_a3;
                ent_wd_d[i] = s_wd;
                ent_pc_d[i] = s_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: starvation counter and stall request
    // ------------------------------------------------------------------
    always_comb begin
        starve_d = starve_q;
        if (pop) begin
            starve_d = 4'd0;
        end else if (starve_inc && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end

        stall_d = stall_q;
        if (starve_inc && (starve_d == LIMIT)) begin
            stall_d = 1'b1;
        end
        // Nothing left that could be starved: either the waiting entry got
        // its write, or every remaining entry has been cancelled.
        if (pop_valid || (ent_v_d == '0)) begin
            stall_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ent_v_q  <= '0;
            starve_q <= 4'd0;
            stall_q  <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ent_v_q  <= ent_v_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage carries no reset; its valid bit qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_a3_q[i] <= ent_a3_d[i];
            ent_wd_q[i] <= ent_wd_d[i];
            ent_pc_q[i] <= ent_pc_d[i];
        end
    end

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grf_wport_arbiter
//
// Directed bench for grf_wport_arbiter (DEPTH=2, STARVE_LIMIT=4). Inputs are
// driven just after the falling edge and outputs sampled 1 time unit later,
// so every check sits in the middle of the low phase.
// -----------------------------------------------------------------------------
module tb_grf_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic [31:0] p_pc;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_a3;
    logic [31:0] s_wd;
    logic [31:0] s_pc;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;
    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic        q_rs_busy;
    logic        q_rt_busy;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grf_wport_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_we      (p_we),
        .p_a3      (p_a3),
        .p_wd      (p_wd),
        .p_pc      (p_pc),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a3      (s_a3),
        .s_wd      (s_wd),
        .s_pc      (s_pc),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc),
        .q_rs      (q_rs),
        .q_rt      (q_rt),
        .q_rs_busy (q_rs_busy),
        .q_rt_busy (q_rt_busy),
        .stall_req (stall_req)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_p(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] pc);
        p_we = we;
        p_a3 = a3;
        p_wd = wd;
        p_pc = pc;
    endtask

    task automatic set_s(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                         input logic [31:0] pc);
        s_valid = v;
        s_a3    = a3;
        s_wd    = wd;
        s_pc    = pc;
    endtask

    // Move to the next low phase and let combinational outputs settle
    // after the caller has changed inputs.
    task automatic begin_cycle(input string what);
        @(negedge clk);
        $display("[%0t] cycle: %s", $time, what);
    endtask

    initial begin
        reset = 1'b0;
        q_rs  = 5'd0;
        q_rt  = 5'd0;
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        set_s(1'b0, 5'd0, 32'h0, 32'h0);

        // ---------------- reset: two edges, requests must be ignored
        begin_cycle("reset 1");
        set_p(1'b1, 5'd4, 32'h44, 32'h40);
        set_s(1'b1, 5'd9, 32'h99, 32'h90);
        #1;
        check("rst1_s_ready", s_ready, 0);
        check("rst1_grf_we", grf_we, 0);
        begin_cycle("reset 2");
        #1;
        check("rst2_s_ready", s_ready, 0);
        check("rst2_grf_we", grf_we, 0);

        // ---------------- idle after release
        begin_cycle("idle after reset");
        reset = 1'b1;
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        set_s(1'b0, 5'd0, 32'h0, 32'h0);
        q_rs = 5'd9;
        q_rt = 5'd4;
        #1;
        check("idle_s_ready", s_ready, 1);
        check("idle_grf_we", grf_we, 0);
        check("idle_stall", stall_req, 0);
        check("idle_rs_busy", q_rs_busy, 0);
        check("idle_rt_busy", q_rt_busy, 0);

        // ---------------- secondary only
        begin_cycle("push a3=9 wd=1234");
        set_s(1'b1, 5'd9, 32'h1234, 32'h100);
        #1;
        check("sec_busy_same_cycle", q_rs_busy, 0);
        check("sec_grf_we_idle", grf_we, 0);
        begin_cycle("drain a3=9");
        set_s(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("sec_rs_busy", q_rs_busy, 1);
        check("sec_grf_we", grf_we, 1);
        check("sec_grf_a3", grf_a3, 9);
        check("sec_grf_wd", grf_wd, 32'h1234);
        check("sec_grf_pc", grf_pc, 32'h100);
        begin_cycle("after drain");
        #1;
        check("sec_busy_after", q_rs_busy, 0);
        check("sec_grf_we_after", grf_we, 0);

        // ---------------- full FIFO under primary on $5
        begin_cycle("primary $5, push a3=10");
        set_p(1'b1, 5'd5, 32'h55, 32'h200);
        set_s(1'b1, 5'd10, 32'hA0, 32'h300);
        #1;
        check("full_ready0", s_ready, 1);
        check("full_grf_a3_p", grf_a3, 5);
        check("full_grf_wd_p", grf_wd, 32'h55);
        begin_cycle("primary $5, push a3=11");
        set_s(1'b1, 5'd11, 32'hB0, 32'h304);
        #1;
        check("full_ready1", s_ready, 1);
        check("full_grf_we_p", grf_we, 1);
        begin_cycle("primary $5, a3=12 held");
        set_s(1'b1, 5'd12, 32'hC0, 32'h308);
        #1;
        check("full_ready_low", s_ready, 0);
        check("full_grf_wd_p2", grf_wd, 32'h55);
        begin_cycle("primary idle, drain first");
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("full_no_passthru", s_ready, 0);
        check("full_drain1_we", grf_we, 1);
        check("full_drain1_a3", grf_a3, 10);
        check("full_drain1_wd", grf_wd, 32'hA0);
        begin_cycle("drain second, push a3=12");
        #1;
        check("full_ready_again", s_ready, 1);
        check("full_drain2_a3", grf_a3, 11);
        check("full_drain2_wd", grf_wd, 32'hB0);
        begin_cycle("drain third");
        set_s(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("full_drain3_we", grf_we, 1);
        check("full_drain3_a3", grf_a3, 12);
        check("full_drain3_pc", grf_pc, 32'h308);

        // ---------------- starvation
        begin_cycle("push a3=13");
        set_s(1'b1, 5'd13, 32'hD0, 32'h400);
        q_rt = 5'd13;
        #1;
        check("stv_ready", s_ready, 1);
        for (int k = 1; k <= 4; k++) begin
            begin_cycle("primary $3 starving");
            set_s(1'b0, 5'd0, 32'h0, 32'h0);
            set_p(1'b1, 5'd3, 32'h33, 32'h500);
            #1;
            check($sformatf("stv_stall_low_%0d", k), stall_req, 0);
            check($sformatf("stv_grf_a3_%0d", k), grf_a3, 3);
            check($sformatf("stv_rt_busy_%0d", k), q_rt_busy, 1);
        end
        begin_cycle("primary drops, drain a3=13");
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("stv_stall_high", stall_req, 1);
        check("stv_drain_we", grf_we, 1);
        check("stv_drain_a3", grf_a3, 13);
        check("stv_drain_wd", grf_wd, 32'hD0);
        begin_cycle("after starvation drain");
        #1;
        check("stv_stall_cleared", stall_req, 0);
        check("stv_grf_we_after", grf_we, 0);
        check("stv_rt_busy_after", q_rt_busy, 0);

        // ---------------- cancellation
        begin_cycle("push a3=7");
        set_s(1'b1, 5'd7, 32'h77, 32'h600);
        q_rs = 5'd7;
        #1;
        check("cnl_busy_before", q_rs_busy, 0);
        begin_cycle("primary writes $7");
        set_s(1'b0, 5'd0, 32'h0, 32'h0);
        set_p(1'b1, 5'd7, 32'h7777, 32'h700);
        #1;
        check("cnl_busy_queued", q_rs_busy, 1);
        check("cnl_grf_we_p", grf_we, 1);
        check("cnl_grf_wd_p", grf_wd, 32'h7777);
        begin_cycle("cancelled head pops");
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("cnl_busy_dropped", q_rs_busy, 0);
        check("cnl_silent_pop", grf_we, 0);

        // same-edge arrival is newer than the primary write and survives
        begin_cycle("push a3=8 with primary $8");
        set_s(1'b1, 5'd8, 32'h88, 32'h800);
        set_p(1'b1, 5'd8, 32'h8888, 32'h880);
        q_rs = 5'd8;
        #1;
        check("new_grf_wd_p", grf_wd, 32'h8888);
        begin_cycle("drain a3=8");
        set_s(1'b0, 5'd0, 32'h0, 32'h0);
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("new_busy", q_rs_busy, 1);
        check("new_grf_we", grf_we, 1);
        check("new_grf_wd", grf_wd, 32'h88);

        // ---------------- zero register
        begin_cycle("primary $0 and secondary $0");
        set_p(1'b1, 5'd0, 32'hDEAD, 32'h900);
        set_s(1'b1, 5'd0, 32'hBAD, 32'h904);
        q_rs = 5'd0;
        #1;
        check("zero_grf_we_p", grf_we, 0);
        check("zero_s_ready", s_ready, 1);
        begin_cycle("after $0 accept");
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        set_s(1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        check("zero_never_written", grf_we, 0);
        check("zero_busy", q_rs_busy, 0);

        // ---------------- reset with two entries queued
        begin_cycle("primary $6, push a3=20");
        set_p(1'b1, 5'd6, 32'h66, 32'hA00);
        set_s(1'b1, 5'd20, 32'h20, 32'hA04);
        q_rs = 5'd20;
        q_rt = 5'd21;
        #1;
        check("mrst_ready0", s_ready, 1);
        begin_cycle("primary $6, push a3=21");
        set_s(1'b1, 5'd21, 32'h21, 32'hA08);
        #1;
        check("mrst_rs_busy", q_rs_busy, 1);
        begin_cycle("reset asserted");
        set_s(1'b0, 5'd0, 32'h0, 32'h0);
        set_p(1'b0, 5'd0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        check("mrst_rt_busy_pre", q_rt_busy, 1);
        check("mrst_grf_we_gated", grf_we, 0);
        check("mrst_ready_gated", s_ready, 0);
        begin_cycle("reset released");
        reset = 1'b1;
        #1;
        check("mrst_rs_busy_clr", q_rs_busy, 0);
        check("mrst_rt_busy_clr", q_rt_busy, 0);
        check("mrst_grf_we", grf_we, 0);
        check("mrst_s_ready", s_ready, 1);
        check("mrst_stall", stall_req, 0);
        begin_cycle("idle after release");
        #1;
        check("mrst_grf_we_later", grf_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/grf_wport_arbiter.md
# grf_wport_arbiter

Arbiter and scheduler for the single GRF write port in the P8 pipeline. The W-stage writeback (primary) always wins the port. Writebacks from long-latency units such as the MDU or bus loads (secondary) are queued in a small FIFO and drained into idle write cycles. The block also reports pending-write hazards to decode and raises a registered stall request when the secondary queue is starved.

## Interface
Parameters:
- DEPTH, 2: secondary FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4: consecutive denied cycles before stall_req is raised; range 1–15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; state clears on a clk edge while reset=0.
- p_we  in  1  primary write enable.
- p_a3  in  5  primary destination register.
- p_wd  in  32  primary write data.
- p_pc  in  32  primary PC, for the GRF write trace.
- s_valid  in  1  secondary request valid.
- s_ready  out  1  secondary accept; equals !full.
- s_a3  in  5  secondary destination register.
- s_wd  in  32  secondary write data.
- s_pc  in  32  secondary PC.
- grf_we  out  1  write enable to GRF.
- grf_a3  out  5  address to GRF.
- grf_wd  out  32  data to GRF.
- grf_pc  out  32  PC to GRF.
- q_rs  in  5  decode lookup, rs.
- q_rt  in  5  decode lookup, rt.
- q_rs_busy  out  1  a queued, valid entry targets q_rs.
- q_rt_busy  out  1  a queued, valid entry targets q_rt.
- stall_req  out  1  registered; asks the pipeline to insert a primary bubble.

## Operation
- Primary is effective when p_we=1 and p_a3≠0. When effective, grf_* = p_* combinationally. Primary is never delayed.
- Secondary handshake: an entry is accepted on an edge with s_valid=1 and s_ready=1. If s_a3=0, the request is accepted and discarded with no allocation.
- FIFO entry fields: {valid, a3, wd, pc}. Pointers wrap modulo DEPTH. count ranges 0..DEPTH. full = (count==DEPTH).
- Drain: when primary is not effective and count>0, the head is popped.
  - Head valid=1: grf_we=1 and grf_a3/wd/pc = head fields.
  - Head valid=0 (cancelled): popped silently with grf_we=0.
- Cancelled heads are also popped during cycles when primary is effective, because no port is needed.
- Cancellation: on an edge with an effective primary write to R, every queued entry with a3==R gets valid cleared. An entry accepted on that same edge is not cancelled, because a secondary arrival counts as newer.
- Busy: q_x_busy = (q_x≠0) and any valid queued entry has a3==q_x. It is computed from registered state only; the current-cycle s_* inputs have no effect.
- Starvation counter (4 bits):
  - Increments on each edge where the head is valid and primary is effective.
  - Clears on any head pop.
- stall_req:
  - Set on the edge where the counter reaches STARVE_LIMIT.
  - Cleared on the edge that pops a valid head.
  - Also cleared if the FIFO empties by cancellation.
- Upstream contract: when stall_req=1, upstream holds p_we=0. If p_we=1 anyway, primary still wins and the counter saturates at 15.
- Simultaneous push and pop: allowed when not full, and count is unchanged. When full, s_ready=0 even if a pop occurs that cycle; there is no pass-through.
- Neither requester ever sees a write to $0: grf_we=0 whenever the selected a3 is 0.

## Timing
- Reset (reset=0 at an edge) takes priority over all events and drops in-flight entries.
  - After the edge: count=0, all valid bits=0, counter=0, stall_req=0, busy outputs=0.
  - While reset=0: s_ready=0 and grf_we=0.
- Primary latency: 0 cycles. The GRF captures the write at the same edge.
- Secondary latency: at least 1 cycle. An entry accepted at edge N can be written at edge N+1 at the earliest, if primary is idle in cycle N+1.
- s_ready, busy outputs and stall_req are functions of registered state only.
- grf_* are combinational from p_* and the FIFO head.

## Test plan
- Reset then idle: drive reset=0 for 2 cycles, then 1 → s_ready=1, grf_we=0, stall_req=0, busy=0.
- Secondary only: accept {a3=9, wd=0x1234} with p_we=0 → q_rs_busy=1 for q_rs=9 for 1 cycle; next cycle grf_we=1, a3=9, wd=0x1234; busy then 0.
- Full FIFO: push 2 entries while p_we=1 on $5 → s_ready=0. Third s_valid is held until the first drain, and the drains follow FIFO order.
- Starvation: queue 1 entry, hold p_we=1 on $3 → stall_req=1 after 4 cycles. Then drop p_we → entry written, stall_req=0 at that edge.
- Cancellation: queue a3=7, then primary writes $7 → busy for 7 drops next cycle. The entry pops with grf_we=0, and $7 is written with the primary data.
- Zero register and mid-operation reset: s_a3=0 is accepted and never written. Reset asserted with 2 entries queued → count=0 and no secondary writes after release.
